cam_pixel_packer: RTL and testbench
===================================

// Module: cam_pixel_packer
// PURPOSE
//  Fabric front-end feeding the capture MSS: accepts the 8-bit camera pixel stream, packs 4 pixels
//  per 32-bit word, buffers words in a FIFO and serves them to the Cortex-M3 over an APB3 slave.
//  Sits between the camera readout logic and the MSS fabric interface.
//  IRQ tells firmware when enough data is buffered.
// PARAMETERS
//  FIFO_DEPTH   64   words in FIFO; power of 2, 4..256
//  IRQ_THRESH   16   IRQ asserted while FIFO level >= IRQ_THRESH; must be 1..FIFO_DEPTH
// PORTS
//  SYSCLK     in   1   single clock; all logic on rising edge
//  RESET      in   1   synchronous, active-high reset
//  PIX_DATA   in   8   pixel value
//  PIX_VALID  in   1   PIX_DATA valid this cycle; no backpressure
//  PIX_SOF    in   1   qualified by PIX_VALID: first pixel of frame
//  PIX_EOL    in   1   qualified by PIX_VALID: last pixel of line
//  PSEL       in   1   APB3 select
//  PENABLE    in   1   APB3 access phase
//  PWRITE     in   1   APB3 direction
//  PADDR      in   4   byte address; [1:0] ignored
//  PWDATA     in   32  write data
//  PRDATA     out  32  read data; 0 when no read access
//  PREADY     out  1   tied 1 (zero wait states)
//  PSLVERR    out  1   1 during access phase to an unmapped address, else 0
//  IRQ        out  1   level interrupt
// BEHAVIOUR
//  Reset: all outputs 0 except PREADY=1. FIFO empty, packer index 0, CTRL=0, stickies 0, FRAME_CNT 0.
//  Registers: 0x0 DATA (RO, pop); 0x4 STATUS (RO); 0x8 CTRL (RW). Write to DATA/STATUS is ignored.
//  STATUS: [8:0]=level, [9]=empty, [10]=full, [11]=OVERFLOW, [12]=UNDERRUN, [23:16]=FRAME_CNT.
//  CTRL: [0]=ENABLE (RW); [1]=CLEAR (write 1, self-clears, reads 0).
//  Access = PSEL&PENABLE. Writes commit at access cycle edge. PRDATA is driven combinationally in the access cycle.
//  Packer, only while ENABLE=1:
//   - Pixel n of a word goes to bits [8n+7:8n], so the first pixel is in [7:0].
//   - Word pushed the cycle after the 4th pixel is accepted, giving 1-cycle latency PIX_VALID->FIFO.
//   - PIX_EOL with 1-3 pixels held: push a zero-padded partial word. Lines never merge across a word.
//   - PIX_SOF: discard any held partial word, this pixel becomes byte 0, FRAME_CNT+1 (8-bit, wraps 255->0).
//   - SOF and EOL on the same pixel: both apply, giving a 1-pixel word.
//  ENABLE=0: PIX_* ignored, and the held partial word is discarded. FIFO contents are kept and remain readable.
//  FIFO: show-ahead (head word visible on DATA read with no extra cycle).
//   - DATA read while non-empty returns the head and pops it at the end of the access cycle.
//   - DATA read while empty returns 0x00000000, no pop, and sets UNDERRUN.
//   - Push while full, with no pop in the same cycle: word dropped, OVERFLOW set, contents unchanged.
//   - Push and pop in the same cycle: both happen, even when full; level unchanged, no OVERFLOW.
//   - Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
//  CLEAR: at that edge empty the FIFO and reset packer, OVERFLOW, UNDERRUN and FRAME_CNT.
//   - ENABLE takes the written bit[0].
//   - A pixel arriving in the same cycle is dropped.
//  IRQ = ENABLE & (level >= IRQ_THRESH), registered (1 cycle after level change).
//  RESET mid-frame/mid-access: everything returns to reset state next edge; partial data lost.
// STRUCTURE
//  capture_defs.vh (shared include): register offsets, STATUS/CTRL bit positions, pixel/word widths.
//  One sub-module: cap_fifo_sync (WIDTH, DEPTH). Synchronous show-ahead FIFO with push/pop/flush,
//   level/full/empty outputs; overflow/underflow handling stays in the parent.
//  Parent holds packer, APB decode, status/ctrl regs, IRQ.
// TESTING
//  1. Write CTRL=1, SOF + 8 pixels 0x01..0x08 with EOL on last -> two DATA reads return 0x04030201, 0x08070605; STATUS.empty=1.
//  2. Line of 6 pixels 0xA0..0xA5, EOL on last -> 0xA3A2A1A0 then 0x0000A5A4.
//  3. SOF after 2 pixels of an earlier frame -> partial discarded, FRAME_CNT increments; 256 SOFs -> FRAME_CNT back to 0.
//  4. Fill FIFO_DEPTH+1 words without reads -> full=1, OVERFLOW=1, first FIFO_DEPTH words read back intact.
//     Full FIFO with push and DATA read in the same cycle -> no OVERFLOW, level stays FIFO_DEPTH.
//  5. DATA read when empty -> PRDATA=0, UNDERRUN=1. Read address 0xC -> PSLVERR=1.
//     CLEAR -> level=0, stickies=0, CTRL reads 0x1 when written 0x3.
//  6. IRQ: level 15->16 -> IRQ rises 1 cycle later; ENABLE=0 -> IRQ=0.
//     RESET asserted mid-line -> all status zero, no stale partial word after re-enable.

Source files
------------

// File: rtl/cam_pixel_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_pixel_packer_pkg : register map, bit positions and widths for the packer |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
package cam_pixel_packer_pkg;

  localparam int c_pix_w  = 8;
  localparam int c_word_w = 32;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  localparam int c_st_empty  = 9;
  localparam int c_st_full   = 10;
  localparam int c_st_ovf    = 11;
  localparam int c_st_udr    = 12;
  localparam int c_st_fc_lsb = 16;

  localparam int c_ctrl_enable = 0;
  localparam int c_ctrl_clear  = 1;

  function automatic logic [c_word_w-1:0] put_byte(input logic [c_word_w-1:0] w,
                                                    input logic [1:0]          idx,
                                                    input logic [c_pix_w-1:0]  b);
    logic [c_word_w-1:0] r;
    r = w;
    r[{idx, 3'b000} +: c_pix_w] = b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pixel_packer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cap_fifo_sync : synchronous show-ahead FIFO with flush and level outputs     |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module cap_fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == (c_aw+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_wr = i_push & (~o_full | i_pop);
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/cam_pixel_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_pixel_packer : packs 8-bit pixels into 32-bit words, APB3 FIFO readout   |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module cam_pixel_packer
  import cam_pixel_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int IRQ_THRESH = 16
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic [7:0]  PIX_DATA,
  input  logic        PIX_VALID,
  input  logic        PIX_SOF,
  input  logic        PIX_EOL,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  localparam int c_lw = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_lw-1:0] c_thresh = c_lw'(IRQ_THRESH);

  reg_sel_e            w_sel;
  logic                w_access;
  logic                w_rd_access;
  logic                w_data_rd;
  logic                w_ctrl_wr;
  logic                w_clear;
  logic                w_pop;
  logic                w_underrun;
  logic                w_pix_take;
  logic [1:0]          w_base_idx;
  logic [c_word_w-1:0] w_base_word;
  logic [c_word_w-1:0] w_new_word;
  logic                w_word_done;
  logic [c_word_w-1:0] w_dout;
  logic [c_lw-1:0]     w_level;
  logic                w_full;
  logic                w_empty;
  logic [31:0]         w_status;
  logic                w_unused;

  logic                r_enable;
  logic [1:0]          r_idx;
  logic [c_word_w-1:0] r_word;
  logic                r_push;
  logic [c_word_w-1:0] r_push_word;
  logic [7:0]          r_frame_cnt;
  logic                r_ovf;
  logic                r_udr;
  logic                r_irq;

  assign w_access    = PSEL & PENABLE;
  assign w_sel       = reg_sel_e'(PADDR[3:2]);
  assign w_rd_access = w_access & ~PWRITE;
  assign w_data_rd   = w_rd_access & (w_sel == REG_DATA);
  assign w_pop       = w_data_rd & ~w_empty;
  assign w_underrun  = w_data_rd & w_empty;
  assign w_ctrl_wr   = w_access & PWRITE & (w_sel == REG_CTRL);
  assign w_clear     = w_ctrl_wr & PWDATA[c_ctrl_clear];
  assign w_pix_take  = PIX_VALID & r_enable & ~w_clear;
  assign w_unused    = ^{PADDR[1:0], PWDATA[31:2]};

  // SOF restarts the word at byte 0, dropping whatever was held.
  assign w_base_idx  = PIX_SOF ? 2'd0 : r_idx;
  assign w_base_word = PIX_SOF ? '0 : r_word;
  assign w_new_word  = put_byte(w_base_word, w_base_idx, PIX_DATA);
  assign w_word_done = (w_base_idx == 2'd3) | PIX_EOL;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      r_enable <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= PWDATA[c_ctrl_enable];
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET || w_clear) begin
      r_idx       <= '0;
      r_word      <= '0;
      r_push      <= 1'b0;
      r_push_word <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_pix_take) begin
        if (PIX_SOF) r_frame_cnt <= r_frame_cnt + 8'd1;
        if (w_word_done) begin
          r_push      <= 1'b1;
          r_push_word <= w_new_word;
          r_idx       <= '0;
          r_word      <= '0;
        end else begin
          r_idx  <= w_base_idx + 2'd1;
          r_word <= w_new_word;
        end
      end else if (!r_enable) begin
        r_idx  <= '0;
        r_word <= '0;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET || w_clear) begin
      r_ovf <= 1'b0;
      r_udr <= 1'b0;
    end else begin
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_underrun)                 r_udr <= 1'b1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) r_irq <= 1'b0;
    else       r_irq <= r_enable & (w_level >= c_thresh);
  end

  cap_fifo_sync #(
    .WIDTH (c_word_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (SYSCLK),
    .rst     (RESET),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_flush (w_clear),
    .i_din   (r_push_word),
    .o_dout  (w_dout),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status                            = '0;
    w_status[8:0]                       = 9'(w_level);
    w_status[c_st_empty]                = w_empty;
    w_status[c_st_full]                 = w_full;
    w_status[c_st_ovf]                  = r_ovf;
    w_status[c_st_udr]                  = r_udr;
    w_status[c_st_fc_lsb +: 8]          = r_frame_cnt;
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd_access) begin
      case (w_sel)
        REG_DATA:   PRDATA = w_empty ? '0 : w_dout;
        REG_STATUS: PRDATA = w_status;
        REG_CTRL:   PRDATA = {31'd0, r_enable};
        default:    PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & (w_sel == REG_NONE);
  assign IRQ     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cam_pixel_packer : directed self-checking bench for cam_pixel_packer      |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_cam_pixel_packer;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic [7:0]  PIX_DATA;
  logic        PIX_VALID, PIX_SOF, PIX_EOL;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;

  int total = 0;
  int bad   = 0;

  cam_pixel_packer #(.FIFO_DEPTH(64), .IRQ_THRESH(16)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pix(input logic [7:0] d, input logic sof, input logic eol);
    PIX_VALID = 1'b1; PIX_DATA = d; PIX_SOF = sof; PIX_EOL = eol;
    tick();
    PIX_VALID = 1'b0; PIX_SOF = 1'b0; PIX_EOL = 1'b0; PIX_DATA = '0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*i);
    b1 = 8'(4*i + 1);
    b2 = 8'(4*i + 2);
    b3 = 8'(4*i + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_fill_word(input int i, input logic sof);
    pix(8'(4*i),     sof,  1'b0);
    pix(8'(4*i + 1), 1'b0, 1'b0);
    pix(8'(4*i + 2), 1'b0, 1'b0);
    pix(8'(4*i + 3), 1'b0, 1'b0);
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    RESET = 1'b1; PIX_DATA = '0; PIX_VALID = 1'b0; PIX_SOF = 1'b0; PIX_EOL = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tick(); tick();
    RESET = 1'b0;
    tick();

    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", {31'd0, PREADY}, 32'h1);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
    chk("rst_irq", {31'd0, IRQ}, 32'h0);
    apb_read(4'h4, rd, err);
    chk("rst_status", rd, 32'h0000_0200);
    apb_read(4'h8, rd, err);
    chk("rst_ctrl", rd, 32'h0);

    // Two full words from one line
    apb_write(4'h8, 32'h1);
    pix(8'h01, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) pix(8'(k), 1'b0, k == 8);
    apb_read(4'h0, rd, err);
    chk("t1_word0", rd, 32'h0403_0201);
    apb_read(4'h0, rd, err);
    chk("t1_word1", rd, 32'h0807_0605);
    apb_read(4'h4, rd, err);
    chk("t1_status", rd, 32'h0001_0200);

    // Line ending on a partial word
    for (int k = 0; k < 6; k++) pix(8'hA0 + 8'(k), 1'b0, k == 5);
    apb_read(4'h0, rd, err);
    chk("t2_word0", rd, 32'hA3A2_A1A0);
    apb_read(4'h0, rd, err);
    chk("t2_partial", rd, 32'h0000_A5A4);

    // SOF discards a held partial word
    pix(8'h11, 1'b0, 1'b0);
    pix(8'h12, 1'b0, 1'b0);
    pix(8'h21, 1'b1, 1'b0);
    pix(8'h22, 1'b0, 1'b0);
    pix(8'h23, 1'b0, 1'b0);
    pix(8'h24, 1'b0, 1'b1);
    apb_read(4'h0, rd, err);
    chk("t3_sof_word", rd, 32'h2423_2221);
    apb_read(4'h4, rd, err);
    chk("t3_fc2", rd, 32'h0002_0200);
    for (int k = 0; k < 254; k++) pix(8'hEE, 1'b1, 1'b0);
    apb_read(4'h4, rd, err);
    chk("t3_fc_wrap", rd, 32'h0000_0200);

    // Fill to full, then push and pop on the same edge
    for (int i = 0; i < 64; i++) push_fill_word(i, i == 0);
    tick(); tick();
    apb_read(4'h4, rd, err);
    chk("t4_full", rd, 32'h0001_0440);
    chk("t4_irq_full", {31'd0, IRQ}, 32'h1);
    pix(8'(4*64),     1'b0, 1'b0);
    pix(8'(4*64 + 1), 1'b0, 1'b0);
    pix(8'(4*64 + 2), 1'b0, 1'b0);
    PIX_VALID = 1'b1; PIX_DATA = 8'(4*64 + 3);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 4'h0; PENABLE = 1'b0;
    tick();
    PIX_VALID = 1'b0; PIX_DATA = '0;
    PENABLE = 1'b1;
    #1;
    chk("t4_simul_rd", PRDATA, fill_word(0));
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(4'h4, rd, err);
    chk("t4_simul_status", rd, 32'h0001_0440);
    push_fill_word(65, 1'b0);
    tick(); tick();
    apb_read(4'h4, rd, err);
    chk("t4_overflow", rd, 32'h0001_0C40);
    for (int i = 1; i <= 64; i++) begin
      apb_read(4'h0, rd, err);
      chk($sformatf("t4_read%0d", i), rd, fill_word(i));
    end
    apb_read(4'h4, rd, err);
    chk("t4_drained", rd, 32'h0001_0A00);

    // Underrun, unmapped address, CLEAR
    apb_read(4'h0, rd, err);
    chk("t5_empty_rd", rd, 32'h0);
    apb_read(4'h4, rd, err);
    chk("t5_underrun", rd, 32'h0001_1A00);
    apb_read(4'hC, rd, err);
    chk("t5_slverr", {31'd0, err}, 32'h1);
    chk("t5_slverr_data", rd, 32'h0);
    push_fill_word(3, 1'b0);
    tick();
    apb_write(4'h8, 32'h3);
    apb_read(4'h4, rd, err);
    chk("t5_clear_status", rd, 32'h0000_0200);
    apb_read(4'h8, rd, err);
    chk("t5_ctrl", rd, 32'h1);

    // IRQ threshold crossing and disable
    for (int i = 0; i < 15; i++) push_fill_word(i, 1'b0);
    tick(); tick();
    chk("t6_irq_15", {31'd0, IRQ}, 32'h0);
    apb_read(4'h4, rd, err);
    chk("t6_level15", rd, 32'h0000_000F);
    push_fill_word(15, 1'b0);
    chk("t6_irq_e1", {31'd0, IRQ}, 32'h0);
    tick();
    chk("t6_irq_e2", {31'd0, IRQ}, 32'h0);
    tick();
    chk("t6_irq_e3", {31'd0, IRQ}, 32'h1);
    apb_write(4'h8, 32'h0);
    tick();
    chk("t6_irq_dis", {31'd0, IRQ}, 32'h0);
    apb_read(4'h4, rd, err);
    chk("t6_kept", rd, 32'h0000_0010);

    // Reset mid-line
    apb_write(4'h8, 32'h1);
    pix(8'h77, 1'b0, 1'b0);
    pix(8'h78, 1'b0, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6_rst_irq", {31'd0, IRQ}, 32'h0);
    apb_read(4'h4, rd, err);
    chk("t6_rst_status", rd, 32'h0000_0200);
    apb_read(4'h8, rd, err);
    chk("t6_rst_ctrl", rd, 32'h0);
    apb_write(4'h8, 32'h1);
    pix(8'h55, 1'b0, 1'b0);
    pix(8'h66, 1'b0, 1'b1);
    apb_read(4'h0, rd, err);
    chk("t6_no_stale", rd, 32'h0000_6655);
    apb_read(4'h4, rd, err);
    chk("t6_final_status", rd, 32'h0000_0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
